usb_ep8_cmd_reader: RTL

- Host-to-FPGA side of the FX2 slave-FIFO interface, the read-direction partner of the EP6 IN image writer.
- Drains EP8 OUT words from the FX2 by driving FIFOADR, SLOE and SLRD on usb_clk.
- Parses words into sync-framed command packets and issues one-cycle command strobes to camera, DDR3 and capture-control logic.
- Shares the FX2 control pins with the EP6 writer through a busy/idle handshake.

---
 rtl/usb_fx2_pkg.sv | 39 +++
 rtl/usb_cmd_parser.sv | 82 ++++++++
 rtl/usb_ep8_cmd_reader.sv | 111 +++++++++++
 3 files changed

// File: rtl/usb_fx2_pkg.sv
// Shared FX2 slave-FIFO definitions for the EP6 writer and EP8 reader.
// FIFOADR codes, packet sync words, control-pin encodings and state types.
package usb_fx2_pkg;

  localparam logic [1:0] FIFOADR_EP2 = 2'b00;
  localparam logic [1:0] FIFOADR_EP4 = 2'b01;
  localparam logic [1:0] FIFOADR_EP6 = 2'b10;
  localparam logic [1:0] FIFOADR_EP8 = 2'b11;

  localparam logic [15:0] SYNC_HI = 16'h7CD2;
  localparam logic [15:0] SYNC_LO = 16'h15D8;

  // {SLOE, SLWR, SLRD}, all active low
  localparam logic [2:0] FX2_CMD_WR  = 3'b101;
  localparam logic [2:0] FX2_CMD_RD  = 3'b110;
  localparam logic [2:0] FX2_CMD_NOP = 3'b111;

  typedef enum logic [2:0] {
    R_IDLE,
    R_SEL,
    R_OE,
    R_RD,
    R_GAP
  } rd_state_e;

  typedef enum logic [1:0] {
    P_SYNC0,
    P_SYNC1,
    P_CMD,
    P_DATA
  } parse_state_e;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

endpackage

// File: rtl/usb_cmd_parser.sv
// Sync-framed command parser: SYNC_HI, SYNC_LO, {op,addr}, data.
// Outputs change only when a full packet lands, then strobe cmd_valid.
module usb_cmd_parser
  import usb_fx2_pkg::*;
#(
  parameter logic [15:0] SYNC_HI = usb_fx2_pkg::SYNC_HI,
  parameter logic [15:0] SYNC_LO = usb_fx2_pkg::SYNC_LO
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] word,
  input  logic        word_valid,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        sync_err
);

  parse_state_e state_q, state_d;
  logic [15:0]  hdr_q, hdr_d;
  cmd_t         cmd_q, cmd_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cmd_d   = cmd_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (word_valid) begin
      unique case (state_q)
        P_SYNC0: begin
          if (word == SYNC_HI) state_d = P_SYNC1;
        end
        P_SYNC1: begin
          if (word == SYNC_LO) begin
            state_d = P_CMD;
          end else if (word != SYNC_HI) begin
            err_d   = 1'b1;
            state_d = P_SYNC0;
          end
        end
        P_CMD: begin
          hdr_d   = word;
          state_d = P_DATA;
        end
        P_DATA: begin
          // op/addr held aside so outputs stay stable until a full packet
          cmd_d   = {hdr_q, word};
          valid_d = 1'b1;
          state_d = P_SYNC0;
        end
        default: state_d = P_SYNC0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= P_SYNC0;
      hdr_q   <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_op    = cmd_q.op;
  assign cmd_addr  = cmd_q.addr;
  assign cmd_data  = cmd_q.data;
  assign sync_err  = err_q;

endmodule

// File: rtl/usb_ep8_cmd_reader.sv
// EP8 OUT reader: drains FX2 words via FIFOADR/SLOE/SLRD, shares the bus
// with the EP6 writer through wr_busy/rd_busy, feeds the command parser.
module usb_ep8_cmd_reader
  import usb_fx2_pkg::*;
#(
  parameter int          FLAG_LAT = 2,
  parameter logic [15:0] SYNC_HI  = usb_fx2_pkg::SYNC_HI,
  parameter logic [15:0] SYNC_LO  = usb_fx2_pkg::SYNC_LO,
  parameter logic [1:0]  EP8_ADR  = usb_fx2_pkg::FIFOADR_EP8
) (
  input  logic        usb_clk,
  input  logic        rst,
  input  logic        flag_ep8_ef,
  input  logic [15:0] usb_data_in,
  input  logic        wr_busy,
  output logic [1:0]  usb_fifo_adr,
  output logic        usb_sloe,
  output logic        usb_slrd,
  output logic        rd_busy,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        sync_err
);

  localparam logic [3:0] GAP_LAST = 4'(FLAG_LAT - 1);

  rd_state_e   state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [1:0]  adr_q, adr_d;
  logic        sloe_q, sloe_d;
  logic        slrd_q, slrd_d;
  logic        busy_q, busy_d;
  logic [15:0] word_q, word_d;
  logic        wv_q, wv_d;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      R_IDLE: if (!wr_busy && flag_ep8_ef) state_d = R_SEL;
      R_SEL:  state_d = R_OE;
      R_OE:   state_d = R_RD;
      R_RD: begin
        state_d = R_GAP;
        gap_d   = '0;
      end
      R_GAP: begin
        // flag is only trusted once the FX2 latency has elapsed
        if (gap_q == GAP_LAST) begin
          if (flag_ep8_ef && !wr_busy) state_d = R_RD;
          else                         state_d = R_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = R_IDLE;
    endcase

    busy_d = (state_d != R_IDLE);
    adr_d  = busy_d ? EP8_ADR : FIFOADR_EP2;
    sloe_d = !(state_d inside {R_OE, R_RD, R_GAP});
    slrd_d = (state_d != R_RD);
    word_d = (state_q == R_RD) ? usb_data_in : word_q;
    wv_d   = (state_q == R_RD);
  end

  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      state_q <= R_IDLE;
      gap_q   <= '0;
      adr_q   <= FIFOADR_EP2;
      sloe_q  <= 1'b1;
      slrd_q  <= 1'b1;
      busy_q  <= 1'b0;
      word_q  <= '0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      adr_q   <= adr_d;
      sloe_q  <= sloe_d;
      slrd_q  <= slrd_d;
      busy_q  <= busy_d;
      word_q  <= word_d;
      wv_q    <= wv_d;
    end
  end

  assign usb_fifo_adr = adr_q;
  assign usb_sloe     = sloe_q;
  assign usb_slrd     = slrd_q;
  assign rd_busy      = busy_q;

  usb_cmd_parser #(
    .SYNC_HI (SYNC_HI),
    .SYNC_LO (SYNC_LO)
  ) u_parser (
    .clk        (usb_clk),
    .rst        (rst),
    .word       (word_q),
    .word_valid (wv_q),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .sync_err   (sync_err)
  );

endmodule
